// File: rtl/iter_alu.sv
// Multi-cycle ALU for the MIPS multi-cycle core: single-cycle logic/arith ops plus
// iterative shift-add multiply and restoring divide behind a start/done handshake.
module iter_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             divz
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_NOT   = 4'd4;
  localparam logic [3:0] OP_PASSA = 4'd5;
  localparam logic [3:0] OP_PASSB = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MULU  = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] workHi_q, workHi_d;
  logic [WIDTH-1:0] workLo_q, workLo_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             ovf_q, ovf_d;
  logic             divz_q, divz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] addRes, subRes, aluY;
  logic             aluOvf;
  logic [WIDTH:0]   mulSum, divShift, divDiff;

  // Single-cycle result, evaluated on the live operands and only registered on accept
  always_comb begin
    addRes = a + b;
    subRes = a - b;
    aluY   = '0;
    aluOvf = 1'b0;
    case (op)
      OP_AND:   aluY = a & b;
      OP_OR:    aluY = a | b;
      OP_ADD: begin
        aluY   = addRes;
        aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (addRes[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        aluY   = subRes;
        aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (subRes[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:   aluY = ~b;
      OP_PASSA: aluY = a;
      OP_PASSB: aluY = b;
      OP_SLT:   aluY = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  aluY = '0;
    endcase
  end

  // One iteration step; the divider's negative trial difference shows in the top bit
  always_comb begin
    mulSum   = {1'b0, workHi_q} + (workLo_q[0] ? {1'b0, opnd_q} : '0);
    divShift = {workHi_q, workLo_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, opnd_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    workHi_d = workHi_q;
    workLo_d = workLo_q;
    y_d      = y_q;
    hi_d     = hi_q;
    ovf_d    = ovf_q;
    divz_d   = divz_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MULU) begin
            opnd_d   = a;
            workHi_d = '0;
            workLo_d = b;
            cnt_d    = '0;
            state_d  = MUL;
          end else if (op == OP_DIVU && b != '0) begin
            opnd_d   = b;
            workHi_d = '0;
            workLo_d = a;
            cnt_d    = '0;
            state_d  = DIV;
          end else if (op == OP_DIVU) begin
            y_d    = '1;
            hi_d   = a;
            ovf_d  = 1'b0;
            divz_d = 1'b1;
            done_d = 1'b1;
          end else begin
            y_d    = aluY;
            hi_d   = '0;
            ovf_d  = aluOvf;
            divz_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (cnt_q == CW'(WIDTH)) begin
          y_d     = workLo_q;
          hi_d    = workHi_q;
          ovf_d   = 1'b0;
          divz_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == MUL) begin
            workHi_d = mulSum[WIDTH:1];
            workLo_d = {mulSum[0], workLo_q[WIDTH-1:1]};
          end else if (!divDiff[WIDTH]) begin
            workHi_d = divDiff[WIDTH-1:0];
            workLo_d = {workLo_q[WIDTH-2:0], 1'b1};
          end else begin
            workHi_d = divShift[WIDTH-1:0];
            workLo_d = {workLo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      workHi_q <= '0;
      workLo_q <= '0;
      y_q      <= '0;
      hi_q     <= '0;
      ovf_q    <= 1'b0;
      divz_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      workHi_q <= workHi_d;
      workLo_q <= workLo_d;
      y_q      <= y_d;
      hi_q     <= hi_d;
      ovf_q    <= ovf_d;
      divz_q   <= divz_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign y    = y_q;
  assign hi   = hi_q;
  assign zero = (y_q == '0);
  assign neg  = y_q[WIDTH-1];
  assign ovf  = ovf_q;
  assign divz = divz_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu at WIDTH=16 and WIDTH=8.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        busy, done, zero, neg, ovf, divz;
  logic [15:0] y, hi;

  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, zero8, neg8, ovf8, divz8;
  logic [7:0]  y8, hi8;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .hi(hi), .zero(zero), .neg(neg),
    .ovf(ovf), .divz(divz)
  );

  iter_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y(y8), .hi(hi8), .zero(zero8), .neg(neg8),
    .ovf(ovf8), .divz(divz8)
  );

  // Present a request for one edge; returns 1ns after the accepting edge
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] z);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = z;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat = number of edges after the accepting edge at which done is seen
  task automatic wait_done(output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      if (busy) busyCnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;
    start8 = 1'b0; op8 = 4'd0; a8 = '0; b8 = '0;
    #12;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (y !== 16'h0 || hi !== 16'h0) $display("FAIL reset_y_hi got %h/%h want 0000/0000", y, hi); else passed++;
    total++; if (zero !== 1'b1 || ovf !== 1'b0 || divz !== 1'b0) $display("FAIL reset_flags got z%b o%b d%b want z1 o0 d0", zero, ovf, divz); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_op;
    int doneSeen;
    issue(4'd5, 16'h0055, 16'h0000);
    @(negedge clk);
    total++; if (y !== 16'h0055) $display("FAIL passa_y got %h want 0055", y); else passed++;
    issue(4'd8, 16'd300, 16'd500);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_busy_done got %b%b want 00", busy, done); else passed++;
    total++; if (y !== 16'h0 || hi !== 16'h0 || zero !== 1'b1) $display("FAIL midrst_y got %h/%h z%b want 0000/0000 z1", y, hi, zero); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    total++; if (doneSeen !== 0) $display("FAIL midrst_no_done got %0d active cycles want 0", doneSeen); else passed++;
    issue(4'd2, 16'd3, 16'd4);
    @(negedge clk);
    total++; if (done !== 1'b1 || y !== 16'd7) $display("FAIL midrst_add got done%b y%h want done1 y0007", done, y); else passed++;
  endtask

  task automatic test_single_cycle;
    int lat, bc;
    issue(4'd2, 16'h7FFF, 16'h0001);
    wait_done(lat, bc);
    total++; if (lat !== 0 || bc !== 0) $display("FAIL add_latency got lat%0d busy%0d want 0/0", lat, bc); else passed++;
    total++; if (y !== 16'h8000 || hi !== 16'h0) $display("FAIL add_y got %h/%h want 8000/0000", y, hi); else passed++;
    total++; if (ovf !== 1'b1 || neg !== 1'b1 || zero !== 1'b0 || divz !== 1'b0) $display("FAIL add_flags got o%b n%b z%b d%b want o1 n1 z0 d0", ovf, neg, zero, divz); else passed++;
    issue(4'd3, 16'h0005, 16'h0005);
    @(negedge clk);
    total++; if (y !== 16'h0 || zero !== 1'b1 || ovf !== 1'b0) $display("FAIL sub_zero got y%h z%b o%b want y0000 z1 o0", y, zero, ovf); else passed++;
    issue(4'd3, 16'h8000, 16'h0001);
    @(negedge clk);
    total++; if (y !== 16'h7FFF || ovf !== 1'b1) $display("FAIL sub_ovf got y%h o%b want y7fff o1", y, ovf); else passed++;
    issue(4'd7, 16'hFFFF, 16'h0001);
    @(negedge clk);
    total++; if (y !== 16'h0001) $display("FAIL slt_neg got %h want 0001", y); else passed++;
    issue(4'd7, 16'h0001, 16'hFFFF);
    @(negedge clk);
    total++; if (y !== 16'h0000) $display("FAIL slt_pos got %h want 0000", y); else passed++;
    issue(4'd4, 16'h1234, 16'h0F0F);
    @(negedge clk);
    total++; if (y !== 16'hF0F0 || neg !== 1'b1) $display("FAIL not_y got %h n%b want f0f0 n1", y, neg); else passed++;
    issue(4'd0, 16'hFF00, 16'h0FF0);
    @(negedge clk);
    total++; if (y !== 16'h0F00) $display("FAIL and_y got %h want 0f00", y); else passed++;
    issue(4'd1, 16'hFF00, 16'h0FF0);
    @(negedge clk);
    total++; if (y !== 16'hFFF0) $display("FAIL or_y got %h want fff0", y); else passed++;
    issue(4'd6, 16'h1111, 16'h2222);
    @(negedge clk);
    total++; if (y !== 16'h2222) $display("FAIL passb_y got %h want 2222", y); else passed++;
    issue(4'd13, 16'h1111, 16'h2222);
    @(negedge clk);
    total++; if (done !== 1'b1 || y !== 16'h0 || hi !== 16'h0) $display("FAIL op13 got done%b y%h hi%h want 1/0000/0000", done, y, hi); else passed++;
  endtask

  task automatic test_mul;
    int lat, bc;
    issue(4'd8, 16'd300, 16'd500);
    a = 16'hDEAD; b = 16'hBEEF; op = 4'd2;
    wait_done(lat, bc);
    total++; if (lat !== 17 || bc !== 17) $display("FAIL mul_latency got lat%0d busy%0d want 17/17", lat, bc); else passed++;
    total++; if (hi !== 16'h0002 || y !== 16'h49F0 || busy !== 1'b0) $display("FAIL mul_300x500 got %h_%h busy%b want 0002_49f0 busy0", hi, y, busy); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0 || y !== 16'h49F0) $display("FAIL mul_done_pulse got done%b y%h want 0/49f0", done, y); else passed++;
    issue(4'd8, 16'hFFFF, 16'hFFFF);
    wait_done(lat, bc);
    total++; if (hi !== 16'hFFFE || y !== 16'h0001 || ovf !== 1'b0) $display("FAIL mul_max got %h_%h o%b want fffe_0001 o0", hi, y, ovf); else passed++;
  endtask

  task automatic test_div;
    int lat, bc;
    issue(4'd9, 16'd1000, 16'd7);
    wait_done(lat, bc);
    total++; if (lat !== 17) $display("FAIL div_latency got %0d want 17", lat); else passed++;
    total++; if (y !== 16'h008E || hi !== 16'h0006 || divz !== 1'b0) $display("FAIL div_1000_7 got q%h r%h d%b want 008e/0006/0", y, hi, divz); else passed++;
    issue(4'd9, 16'd5, 16'd9);
    wait_done(lat, bc);
    total++; if (y !== 16'h0 || hi !== 16'd5 || zero !== 1'b1) $display("FAIL div_5_9 got q%h r%h z%b want 0000/0005/1", y, hi, zero); else passed++;
    issue(4'd9, 16'h1234, 16'h0000);
    wait_done(lat, bc);
    total++; if (lat !== 0 || bc !== 0) $display("FAIL divz_latency got lat%0d busy%0d want 0/0", lat, bc); else passed++;
    total++; if (y !== 16'hFFFF || hi !== 16'h1234 || divz !== 1'b1) $display("FAIL divz_result got y%h hi%h d%b want ffff/1234/1", y, hi, divz); else passed++;
    issue(4'd9, 16'hFFFF, 16'h0001);
    wait_done(lat, bc);
    total++; if (y !== 16'hFFFF || hi !== 16'h0 || divz !== 1'b0) $display("FAIL div_by_one got q%h r%h d%b want ffff/0000/0", y, hi, divz); else passed++;
  endtask

  task automatic test_busy_ignore;
    int lat, bc;
    issue(4'd8, 16'd300, 16'd500);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 4'd2; a = 16'd1; b = 16'd1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++; if (done !== 1'b1 || hi !== 16'h0002 || y !== 16'h49F0) $display("FAIL ignore_mul got done%b %h_%h want 1 0002_49f0", done, hi, y); else passed++;
    repeat (2) @(negedge clk);
    total++; if (done !== 1'b0 || y !== 16'h49F0) $display("FAIL ignore_no_add got done%b y%h want 0/49f0", done, y); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    issue(4'd8, 16'hFFFF, 16'hFFFF);
    wait_done(lat, bc);
    total++; if (done !== 1'b1 || hi !== 16'hFFFE) $display("FAIL b2b_mul got done%b hi%h want 1/fffe", done, hi); else passed++;
    start = 1'b1; op = 4'd9; a = 16'd1000; b = 16'd7;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    total++; if (lat !== 17 || y !== 16'h008E || hi !== 16'h0006) $display("FAIL b2b_div got lat%0d q%h r%h want 17/008e/0006", lat, y, hi); else passed++;
  endtask

  task automatic test_width8;
    int lat;
    @(negedge clk);
    start8 = 1'b1; op8 = 4'd8; a8 = 8'hFF; b8 = 8'h02;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 9) $display("FAIL w8_mul_latency got %0d want 9", lat); else passed++;
    total++; if (hi8 !== 8'h01 || y8 !== 8'hFE) $display("FAIL w8_mul got %h_%h want 01_fe", hi8, y8); else passed++;
    @(negedge clk);
    start8 = 1'b1; op8 = 4'd12; a8 = 8'h5A; b8 = 8'hA5;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    total++; if (done8 !== 1'b1 || busy8 !== 1'b0 || y8 !== 8'h00 || hi8 !== 8'h00) $display("FAIL w8_op12 got done%b busy%b y%h hi%h want 1/0/00/00", done8, busy8, y8, hi8); else passed++;
  endtask

  initial begin
    test_reset;
    test_reset_mid_op;
    test_single_cycle;
    test_mul;
    test_div;
    test_busy_ignore;
    test_back_to_back;
    test_width8;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
